// File: rtl/calc_sched_if.sv
// Signal bundle between calc_sched and its neighbours: parser input, ALU issue/return,
// TX encoder result handshake, and status/debug outputs.
interface calc_sched_if #(
  parameter int AW = 2
);
  logic        parser_done;
  logic [3:0]  dtype;
  logic [4:0]  operator;
  logic [15:0] src1;
  logic [15:0] src2;

  logic        alu_start;
  logic [3:0]  alu_dtype;
  logic [4:0]  alu_operator;
  logic [15:0] alu_src1;
  logic [15:0] alu_src2;
  logic        alu_done;
  logic [31:0] calc_res;

  // res_valid/res_ready: a result transfers on a rising edge where both are high;
  // until then res_valid stays high and res_data/res_err do not change.
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_err;
  logic        res_ready;

  logic        cmd_drop;
  logic        busy;
  logic [AW:0] fifo_level;
  logic [1:0]  state_dbg;

  modport slave (
    input  parser_done, dtype, operator, src1, src2, alu_done, calc_res, res_ready,
    output alu_start, alu_dtype, alu_operator, alu_src1, alu_src2,
           res_valid, res_data, res_err, cmd_drop, busy, fifo_level, state_dbg
  );

  modport master (
    output parser_done, dtype, operator, src1, src2, alu_done, calc_res, res_ready,
    input  alu_start, alu_dtype, alu_operator, alu_src1, alu_src2,
           res_valid, res_data, res_err, cmd_drop, busy, fifo_level, state_dbg
  );
endinterface

// File: rtl/calc_sched.sv
// Command scheduler: queues parsed commands, issues one at a time to the ALU with a
// wait timeout, and holds each result until the TX encoder takes it.
module calc_sched #(
  parameter int DEPTH   = 4,
  parameter int AW      = 2,
  parameter int TIMEOUT = 255
) (
  input logic         clk,
  input logic         rst,
  calc_sched_if.slave bus
);
  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t        r_state;
  logic [40:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [CW-1:0] r_cnt;
  logic          r_cmd_drop;
  logic          r_alu_start;
  logic [3:0]    r_alu_dtype;
  logic [4:0]    r_alu_operator;
  logic [15:0]   r_alu_src1;
  logic [15:0]   r_alu_src2;
  logic          r_res_valid;
  logic [31:0]   r_res_data;
  logic          r_res_err;

  logic w_full;
  logic w_pop;
  logic w_push;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_full = (r_level == FULL_LVL);
  assign w_pop  = (r_state == S_IDLE) && (r_level != '0);
  assign w_push = bus.parser_done && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.dtype, bus.operator, bus.src1, bus.src2};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_cnt          <= '0;
      r_cmd_drop     <= 1'b0;
      r_alu_start    <= 1'b0;
      r_alu_dtype    <= '0;
      r_alu_operator <= '0;
      r_alu_src1     <= '0;
      r_alu_src2     <= '0;
      r_res_valid    <= 1'b0;
      r_res_data     <= '0;
      r_res_err      <= 1'b0;
    end else begin
      r_cmd_drop <= bus.parser_done && w_full && !w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + (AW+1)'(1);
      else if (!w_push && w_pop) r_level <= r_level - (AW+1)'(1);

      r_alu_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_alu_dtype, r_alu_operator, r_alu_src1, r_alu_src2} <= r_mem[r_rd_ptr];
            r_alu_start <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        // A done pulse arriving in the expiry cycle still delivers the real result.
        S_WAIT: begin
          if (bus.alu_done) begin
            r_res_data  <= bus.calc_res;
            r_res_err   <= 1'b0;
            r_res_valid <= 1'b1;
            r_state     <= S_HOLD;
          end else if (r_cnt == CNT_LAST) begin
            r_res_data  <= '0;
            r_res_err   <= 1'b1;
            r_res_valid <= 1'b1;
            r_state     <= S_HOLD;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_HOLD: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.alu_start    = r_alu_start;
  assign bus.alu_dtype    = r_alu_dtype;
  assign bus.alu_operator = r_alu_operator;
  assign bus.alu_src1     = r_alu_src1;
  assign bus.alu_src2     = r_alu_src2;
  assign bus.res_valid    = r_res_valid;
  assign bus.res_data     = r_res_data;
  assign bus.res_err      = r_res_err;
  assign bus.cmd_drop     = r_cmd_drop;
  assign bus.busy         = (r_state != S_IDLE) || (r_level != '0);
  assign bus.fifo_level   = r_level;
  assign bus.state_dbg    = r_state;
endmodule

// File: tb/tb_calc_sched.sv
// Bench for calc_sched: directed scenarios plus randomized traffic, scoreboarded against
// a transaction-level model of commands, ALU answers and the expected result timing.
module tb_calc_sched;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int TO    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  calc_sched_if #(.AW(AW)) bus();
  calc_sched #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [40:0] cmd_q[$];
  logic [32:0] exp_q[$];
  int          explat_q[$];
  int          plan_lat_q[$];
  logic [31:0] plan_res_q[$];
  int n_acc = 0, n_done = 0, n_drops = 0, exp_drops = 0;
  bit rr_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op[1:0])
      2'd0:    return {16'd0, a} + {16'd0, b};
      2'd1:    return {16'd0, a} - {16'd0, b};
      2'd2:    return {16'd0, a} * {16'd0, b};
      default: return {a, b} ^ 32'hA5A5_5A5A;
    endcase
  endfunction

  // lat: 1..TO = ALU answers lat cycles after alu_start; 0 = never; >TO = too late.
  task automatic issue(input logic [3:0] dt, input logic [4:0] op, input logic [15:0] a,
                       input logic [15:0] b, input int lat, input bit acc);
    bus.parser_done = 1'b1;
    bus.dtype = dt; bus.operator = op; bus.src1 = a; bus.src2 = b;
    if (acc) begin
      cmd_q.push_back({dt, op, a, b});
      plan_lat_q.push_back(lat);
      plan_res_q.push_back(alu_fn(op, a, b));
      if (lat >= 1 && lat <= TO) begin
        exp_q.push_back({1'b0, alu_fn(op, a, b)});
        explat_q.push_back(lat + 1);
      end else begin
        exp_q.push_back({1'b1, 32'd0});
        explat_q.push_back(TO + 1);
      end
      n_acc++;
    end else begin
      exp_drops++;
    end
    @(negedge clk);
    bus.parser_done = 1'b0;
  endtask

  task automatic issue_rand(input int lat, input bit acc);
    issue(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 16'($urandom_range(0, 65535)),
          16'($urandom_range(0, 65535)), lat, acc);
  endtask

  function automatic int rand_lat();
    return ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO));
  endfunction

  task automatic drain(input int bound);
    int g = 0;
    while (!(n_acc == n_done && !bus.busy) && g < bound) begin
      @(negedge clk);
      g++;
    end
    check("drain_done", 64'(g < bound), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alu"}, 64'({bus.alu_start, bus.alu_dtype, bus.alu_operator, bus.alu_src1, bus.alu_src2}), 64'd0);
    check({tag, "_res"}, 64'({bus.res_valid, bus.res_data, bus.res_err, bus.cmd_drop, bus.busy, bus.fifo_level}), 64'd0);
  endtask

  // ALU responder: answers each issue according to the plan recorded at stimulus time.
  initial begin
    int          l;
    logic [31:0] r;
    bus.alu_done = 1'b0;
    bus.calc_res = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.alu_start) begin
        l = 0;
        r = '0;
        if (plan_lat_q.size() != 0) begin
          l = plan_lat_q.pop_front();
          r = plan_res_q.pop_front();
        end
        if (l > 0) begin
          repeat (l) @(negedge clk);
          bus.alu_done = 1'b1;
          bus.calc_res = r;
          @(negedge clk);
          bus.alu_done = 1'b0;
          bus.calc_res = $urandom;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rr_rand) bus.res_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: checks every issue and every presented result against the scoreboard.
  bit          in_flight = 1'b0, prev_valid = 1'b0, prev_hs = 1'b0;
  int          hs_age = 100, t_start = 0, cur_lat;
  logic [32:0] prev_res, cur_exp;
  logic [40:0] cap;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        in_flight = 1'b0; prev_valid = 1'b0; prev_hs = 1'b0; hs_age = 100;
        continue;
      end
      t_start++;
      hs_age++;
      if (bus.cmd_drop) n_drops++;
      if (bus.alu_start) begin
        check("one_in_alu", 64'({in_flight, bus.res_valid, hs_age < 2}), 64'd0);
        check("issue_expected", 64'(cmd_q.size() != 0), 64'd1);
        if (cmd_q.size() != 0)
          check("issue_cmd", 64'({bus.alu_dtype, bus.alu_operator, bus.alu_src1, bus.alu_src2}), 64'(cmd_q.pop_front()));
        cap = {bus.alu_dtype, bus.alu_operator, bus.alu_src1, bus.alu_src2};
        in_flight = 1'b1;
        t_start = 0;
      end
      if (prev_hs) check("valid_drop", 64'(bus.res_valid), 64'd0);
      if (bus.res_valid && !prev_valid) begin
        check("result_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          cur_exp = exp_q.pop_front();
          cur_lat = explat_q.pop_front();
          check("result", 64'({bus.res_err, bus.res_data}), 64'(cur_exp));
          check("latency", 64'(t_start), 64'(cur_lat));
          check("alu_stable", 64'({bus.alu_dtype, bus.alu_operator, bus.alu_src1, bus.alu_src2}), 64'(cap));
        end
      end else if (bus.res_valid && !prev_hs) begin
        check("hold_stable", 64'({bus.res_err, bus.res_data}), 64'(prev_res));
      end
      if (bus.res_valid && bus.res_ready) begin
        n_done++;
        in_flight = 1'b0;
        hs_age = 0;
      end
      prev_valid = bus.res_valid;
      prev_hs    = bus.res_valid && bus.res_ready;
      prev_res   = {bus.res_err, bus.res_data};
    end
  end

  initial begin
    int g;
    bus.parser_done = 1'b0;
    bus.dtype = '0; bus.operator = '0; bus.src1 = '0; bus.src2 = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);

    // Single ADD 3+5, ALU answers after 3 cycles.
    bus.res_ready = 1'b1;
    issue(4'h1, 5'd0, 16'd3, 16'd5, 3, 1'b1);
    drain(200);
    check("t1_idle", 64'(bus.busy), 64'd0);

    // ALU answers too late: timeout result, then the stray done must change nothing.
    issue_rand(TO + 5, 1'b1);
    drain(200);
    repeat (8) @(negedge clk);
    check("t3_no_late_effect", 64'({bus.busy, bus.res_valid, bus.fifo_level}), 64'd0);
    check("t3_done_count", 64'(n_done), 64'(n_acc));

    // One command held in the ALU, then five back-to-back pushes: fifth is dropped.
    issue_rand(TO, 1'b1);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) issue_rand(rand_lat(), 1'b1);
    check("t2_level_full", 64'(bus.fifo_level), 64'd4);
    issue_rand(3, 1'b0);
    check("t2_drop", 64'(bus.cmd_drop), 64'd1);
    check("t2_level_hold", 64'(bus.fifo_level), 64'd4);
    drain(1500);
    check("t2_idle", 64'(bus.busy), 64'd0);

    // Result held 20 cycles with a full FIFO, then a push lands on the IDLE pop.
    bus.res_ready = 1'b0;
    issue_rand(2, 1'b1);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) issue_rand(rand_lat(), 1'b1);
    repeat (20) @(negedge clk);
    check("t4_level", 64'(bus.fifo_level), 64'd4);
    check("t4_valid", 64'(bus.res_valid), 64'd1);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    issue_rand(5, 1'b1);
    check("t6_no_drop", 64'(bus.cmd_drop), 64'd0);
    check("t6_level", 64'(bus.fifo_level), 64'd4);
    bus.res_ready = 1'b1;
    drain(1500);

    // Reset while one command waits on the ALU and three are queued.
    issue_rand(0, 1'b1);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) issue_rand(rand_lat(), 1'b1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    cmd_q.delete(); exp_q.delete(); explat_q.delete(); plan_lat_q.delete(); plan_res_q.delete();
    n_acc = 0;
    n_done = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue(4'h2, 5'd1, 16'd100, 16'd58, 3, 1'b1);
    drain(200);

    // Randomized traffic with random backpressure; never more than DEPTH outstanding.
    rr_rand = 1'b1;
    for (int n = 0; n < 60; n++) begin
      g = 0;
      while ((n_acc - n_done) >= DEPTH && g < 500) begin
        @(negedge clk);
        g++;
      end
      check("room_wait", 64'(g < 500), 64'd1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue_rand(rand_lat(), 1'b1);
    end
    rr_rand = 1'b0;
    bus.res_ready = 1'b1;
    drain(3000);

    repeat (3) @(negedge clk);
    check("drop_count", 64'(n_drops), 64'(exp_drops));
    check("final_level", 64'(bus.fifo_level), 64'd0);
    check("final_busy", 64'(bus.busy), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
